// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO.
package fifo_pkg;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'b00,
        FIFO_PART  = 2'b10,
        FIFO_FULL  = 2'b11
    } fifo_cond_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int fifo_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Bus bundle between a FIFO and its producer/consumer.
interface fifo_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) ();
    localparam int CW = fifo_cw(DEPTH);

    // Handshake: write/read are one-cycle requests sampled on the rising edge.
    // A write is taken only while full is low, a read only while empty is low,
    // and neither while flush is high. A taken read returns dout with
    // read_stb high for exactly one cycle after the edge that accepted it.
    logic [WIDTH-1:0] din;
    logic             write;
    logic             read;
    logic             flush;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             read_stb;
    logic [1:0]       condition;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output din, write, read, flush, clr_err,
        input  dout, read_stb, condition, full, empty,
        input  almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  din, write, read, flush, clr_err,
        output dout, read_stb, condition, full, empty,
        output almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage with a registered read port.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array contents are don't-care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy, status and error flags.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input logic         clk,
    input logic         rst,
    fifo_param_if.slave bus
);

    localparam int CW = fifo_cw(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             read_stb;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] dout;
    fifo_cond_t       cond;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Acceptance uses the pre-edge count, so a full FIFO rejects a
    // simultaneous write and an empty FIFO never reads through.
    assign wr_ok = bus.write & ~full  & ~bus.flush;
    assign rd_ok = bus.read  & ~empty & ~bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            read_stb <= 1'b0;
        end else if (bus.flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            read_stb <= 1'b0;
        end else begin
            if (wr_ok) begin
                head <= head + 1'b1;
            end
            if (rd_ok) begin
                tail <= tail + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            read_stb <= rd_ok;
        end
    end

    // A new error event in the same cycle takes priority over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.write & full & ~bus.flush) begin
                overflow <= 1'b1;
            end else if (bus.clr_err) begin
                overflow <= 1'b0;
            end
            if (bus.read & empty & ~bus.flush) begin
                underflow <= 1'b1;
            end else if (bus.clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (head),
        .wdata (bus.din),
        .re    (rd_ok),
        .raddr (tail),
        .rdata (dout)
    );

    always_comb begin
        cond = FIFO_PART;
        if (empty) begin
            cond = FIFO_EMPTY;
        end else if (full) begin
            cond = FIFO_FULL;
        end
    end

    assign bus.dout         = dout;
    assign bus.read_stb     = read_stb;
    assign bus.condition    = cond;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count <= CW'(AE_LEVEL));
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: vector table, corner sequences, random run vs queue model.
module tb_fifo_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fifo_param_if #(.WIDTH(8), .DEPTH(4)) a_if ();
    fifo_param_if #(.WIDTH(8), .DEPTH(8)) b_if ();

    fifo_param #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    int tests = 0;
    int fails = 0;

    // Reference model for instance A (DEPTH 4, AF 2, AE 2)
    logic [7:0] exp_q[$];
    logic [7:0] m_dout;
    logic       m_stb;
    logic       m_ovf;
    logic       m_unf;

    typedef struct {
        logic [7:0] din;
        logic       wr;
        logic       rd;
        logic       fl;
        logic       ce;
        int         cnt;
        logic       stb;
        logic [7:0] dout;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vt[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_dout = 8'h00;
        m_stb  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] din, input logic wr, input logic rd,
                              input logic fl, input logic ce);
        bit f;
        bit e;
        bit set_o;
        bit set_u;
        f     = (exp_q.size() == 4);
        e     = (exp_q.size() == 0);
        set_o = wr && f && !fl;
        set_u = rd && e && !fl;
        m_stb = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (rd && !e) begin
                m_dout = exp_q.pop_front();
                m_stb  = 1'b1;
            end
            if (wr && !f) exp_q.push_back(din);
        end
        if (set_o) m_ovf = 1'b1;
        else if (ce) m_ovf = 1'b0;
        if (set_u) m_unf = 1'b1;
        else if (ce) m_unf = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = exp_q.size();
        check({tag, " count"}, 32'(a_if.count), n);
        check({tag, " empty"}, 32'(a_if.empty), 32'(n == 0));
        check({tag, " full"}, 32'(a_if.full), 32'(n == 4));
        check({tag, " condition"}, 32'(a_if.condition), (n == 0) ? 0 : (n == 4) ? 3 : 2);
        check({tag, " almost_full"}, 32'(a_if.almost_full), 32'(n >= 2));
        check({tag, " almost_empty"}, 32'(a_if.almost_empty), 32'(n <= 2));
        check({tag, " dout"}, 32'(a_if.dout), 32'(m_dout));
        check({tag, " read_stb"}, 32'(a_if.read_stb), 32'(m_stb));
        check({tag, " overflow"}, 32'(a_if.overflow), 32'(m_ovf));
        check({tag, " underflow"}, 32'(a_if.underflow), 32'(m_unf));
    endtask

    task automatic drive_a(input logic [7:0] din, input logic wr, input logic rd,
                           input logic fl, input logic ce, input string tag);
        a_if.din     = din;
        a_if.write   = wr;
        a_if.read    = rd;
        a_if.flush   = fl;
        a_if.clr_err = ce;
        @(posedge clk);
        model_step(din, wr, rd, fl, ce);
        #1;
        check_model(tag);
    endtask

    task automatic drive_b(input logic [7:0] din, input logic wr, input logic rd);
        b_if.din   = din;
        b_if.write = wr;
        b_if.read  = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_if.din = '0; a_if.write = 0; a_if.read = 0; a_if.flush = 0; a_if.clr_err = 0;
        b_if.din = '0; b_if.write = 0; b_if.read = 0; b_if.flush = 0; b_if.clr_err = 0;
        model_reset();

        // Reset state
        #12;
        check_model("reset");
        check("reset b count", 32'(b_if.count), 0);
        check("reset b almost_empty", 32'(b_if.almost_empty), 1);
        #10;
        rst = 1'b0;

        // Basic ordering, then overflow/drain on DEPTH 4
        vt[0]  = '{8'h11, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0};
        vt[1]  = '{8'h22, 1, 0, 0, 0, 2, 0, 8'h00, 0, 0};
        vt[2]  = '{8'h33, 1, 0, 0, 0, 3, 0, 8'h00, 0, 0};
        vt[3]  = '{8'h00, 0, 1, 0, 0, 2, 1, 8'h11, 0, 0};
        vt[4]  = '{8'h00, 0, 1, 0, 0, 1, 1, 8'h22, 0, 0};
        vt[5]  = '{8'h00, 0, 1, 0, 0, 0, 1, 8'h33, 0, 0};
        vt[6]  = '{8'h00, 0, 0, 0, 0, 0, 0, 8'h33, 0, 0};
        vt[7]  = '{8'hA0, 1, 0, 0, 0, 1, 0, 8'h33, 0, 0};
        vt[8]  = '{8'hA1, 1, 0, 0, 0, 2, 0, 8'h33, 0, 0};
        vt[9]  = '{8'hA2, 1, 0, 0, 0, 3, 0, 8'h33, 0, 0};
        vt[10] = '{8'hA3, 1, 0, 0, 0, 4, 0, 8'h33, 0, 0};
        vt[11] = '{8'hA4, 1, 0, 0, 0, 4, 0, 8'h33, 1, 0};
        vt[12] = '{8'h00, 0, 1, 0, 0, 3, 1, 8'hA0, 1, 0};
        vt[13] = '{8'h00, 0, 1, 0, 0, 2, 1, 8'hA1, 1, 0};
        vt[14] = '{8'h00, 0, 1, 0, 0, 1, 1, 8'hA2, 1, 0};
        vt[15] = '{8'h00, 0, 1, 0, 0, 0, 1, 8'hA3, 1, 0};
        vt[16] = '{8'h00, 0, 0, 0, 0, 0, 0, 8'hA3, 1, 0};
        vt[17] = '{8'h00, 0, 0, 0, 1, 0, 0, 8'hA3, 0, 0};
        for (int i = 0; i < 18; i++) begin
            drive_a(vt[i].din, vt[i].wr, vt[i].rd, vt[i].fl, vt[i].ce, $sformatf("vec%0d", i));
            check($sformatf("vec%0d count", i), 32'(a_if.count), vt[i].cnt);
            check($sformatf("vec%0d stb", i), 32'(a_if.read_stb), 32'(vt[i].stb));
            check($sformatf("vec%0d dout", i), 32'(a_if.dout), 32'(vt[i].dout));
            check($sformatf("vec%0d ovf", i), 32'(a_if.overflow), 32'(vt[i].ovf));
            check($sformatf("vec%0d unf", i), 32'(a_if.underflow), 32'(vt[i].unf));
            if (i == 10) check("vec10 condition full", 32'(a_if.condition), 3);
        end

        // Sustained simultaneous read/write at count 2, pointers wrap
        drive_a(8'hB0, 1, 0, 0, 0, "rw fill0");
        drive_a(8'hB1, 1, 0, 0, 0, "rw fill1");
        for (int i = 0; i < 10; i++) begin
            logic [7:0] want;
            want = (i == 0) ? 8'hB0 : (i == 1) ? 8'hB1 : 8'(8'hC0 + i - 2);
            drive_a(8'(8'hC0 + i), 1, 1, 0, 0, $sformatf("rw%0d", i));
            check($sformatf("rw%0d count", i), 32'(a_if.count), 2);
            check($sformatf("rw%0d dout", i), 32'(a_if.dout), 32'(want));
        end
        drive_a(8'h00, 0, 1, 0, 0, "rw drain0");
        check("rw drain0 dout", 32'(a_if.dout), 32'h C8);
        drive_a(8'h00, 0, 1, 0, 0, "rw drain1");
        check("rw drain1 dout", 32'(a_if.dout), 32'h C9);

        // Empty FIFO with read and write together
        drive_a(8'h5A, 1, 1, 0, 0, "empty rw");
        check("empty rw stb", 32'(a_if.read_stb), 0);
        check("empty rw underflow", 32'(a_if.underflow), 1);
        check("empty rw count", 32'(a_if.count), 1);
        drive_a(8'h00, 0, 1, 0, 0, "empty rw read");
        check("empty rw read dout", 32'(a_if.dout), 32'h5A);
        check("empty rw read stb", 32'(a_if.read_stb), 1);
        drive_a(8'h00, 0, 0, 0, 1, "clr_err");
        check("clr_err underflow", 32'(a_if.underflow), 0);

        // Flush overrides requests and raises no errors
        drive_a(8'hD0, 1, 0, 0, 0, "fl w0");
        drive_a(8'hD1, 1, 0, 0, 0, "fl w1");
        drive_a(8'hD2, 1, 0, 0, 0, "fl w2");
        drive_a(8'hEE, 1, 1, 1, 0, "flush");
        check("flush count", 32'(a_if.count), 0);
        check("flush empty", 32'(a_if.empty), 1);
        check("flush stb", 32'(a_if.read_stb), 0);
        check("flush dout holds", 32'(a_if.dout), 32'h5A);
        check("flush errors", 32'({a_if.overflow, a_if.underflow}), 0);

        // Async reset mid-drain
        drive_a(8'hD3, 1, 0, 0, 0, "ar w0");
        drive_a(8'hD4, 1, 0, 0, 0, "ar w1");
        drive_a(8'hD5, 1, 0, 0, 0, "ar w2");
        drive_a(8'h00, 0, 1, 0, 0, "ar r0");
        check("ar r0 stb", 32'(a_if.read_stb), 1);
        a_if.read = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async rst stb", 32'(a_if.read_stb), 0);
        check("async rst count", 32'(a_if.count), 0);
        check("async rst dout", 32'(a_if.dout), 0);
        check("async rst empty", 32'(a_if.empty), 1);
        model_reset();
        #3;
        rst = 1'b0;

        // Threshold edges on DEPTH 8, AF 6, AE 2
        for (int k = 1; k <= 8; k++) begin
            drive_b(8'(k), 1, 0);
            check($sformatf("b k%0d count", k), 32'(b_if.count), k);
            check($sformatf("b k%0d almost_empty", k), 32'(b_if.almost_empty), 32'(k <= 2));
            check($sformatf("b k%0d almost_full", k), 32'(b_if.almost_full), 32'(k >= 6));
        end
        check("b full", 32'(b_if.full), 1);
        check("b condition", 32'(b_if.condition), 3);
        drive_b(8'h00, 0, 1);
        check("b first out", 32'(b_if.dout), 1);
        drive_b(8'h00, 0, 0);

        // Randomised traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            drive_a(8'($urandom_range(0, 255)),
                    $urandom_range(0, 99) < 55,
                    $urandom_range(0, 99) < 50,
                    $urandom_range(0, 31) == 0,
                    $urandom_range(0, 15) == 0,
                    $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
